// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with 16x (configurable) oversampling,
//   3-sample majority vote per bit, false-start rejection, optional parity,
//   one or two stop bits, and a valid/ready output holding register.
//
// Ports
//   clk_100M   : system clock
//   rst        : asynchronous reset, active-high
//   rx         : serial line, idle high, asynchronous to clk_100M
//   data       : received word, LSB first on the line
//   valid      : data/frame_err/parity_err hold a word
//   ready      : consumer takes the word on a cycle with valid && ready
//   frame_err  : a 0 was voted in a stop bit (qualified by valid)
//   parity_err : parity mismatch (qualified by valid), 0 when PARITY=0
//   overrun    : one-cycle pulse, a completed word was dropped
//   busy       : receiver FSM is not idle
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int CLK_FREQ   = 32'sd100_000_000,
    parameter int BAUD_RATE  = 32'sd921600,
    parameter int DATA_BITS  = 32'sd8,
    parameter int PARITY     = 32'sd0,
    parameter int STOP_BITS  = 32'sd1,
    parameter int OVERSAMPLE = 32'sd16
) (
    input  logic                 clk_100M,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    // Rounded clocks-per-sample-tick; 64-bit so CLK_FREQ*10 cannot overflow.
    localparam longint DIV_L = (longint'(CLK_FREQ) * 64'sd10
                               / (longint'(BAUD_RATE) * longint'(OVERSAMPLE))
                               + 64'sd5) / 64'sd10;
    localparam int DIV    = (DIV_L < 64'sd1) ? 32'sd1 : int'(DIV_L);
    localparam int DIV_W  = (DIV > 32'sd1) ? $clog2(DIV) : 32'sd1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = 32'sd4;

    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(DIV - 32'sd1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [SAMP_W-1:0] SAMP_MAX  = SAMP_W'(OVERSAMPLE - 32'sd1);
    localparam logic [SAMP_W-1:0] SAMP_ONE  = {{(SAMP_W-1){1'b0}}, 1'b1};
    localparam logic [SAMP_W-1:0] S_LO      = SAMP_W'(OVERSAMPLE / 32'sd2 - 32'sd1);
    localparam logic [SAMP_W-1:0] S_MID     = SAMP_W'(OVERSAMPLE / 32'sd2);
    localparam logic [SAMP_W-1:0] S_HI      = SAMP_W'(OVERSAMPLE / 32'sd2 + 32'sd1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = {{(BIT_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(DATA_BITS - 32'sd1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 32'sd1);
    localparam logic              HAS_PAR   = (PARITY != 32'sd0);
    localparam logic              ODD_PAR   = (PARITY == 32'sd1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // 2-of-3 majority of the centre samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // True when data bits plus received parity bit do not give the configured parity.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] word,
                                             input logic                 pbit);
        return ((^word) ^ pbit) != ODD_PAR;
    endfunction

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [SAMP_W-1:0]    samp_cnt_r;
    logic                 v_lo_r;
    logic                 v_mid_r;
    logic [2:0]           state_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 ferr_r;
    logic                 perr_r;
    logic                 done_r;
    logic                 busy_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;
    logic                 parity_err_r;
    logic                 overrun_r;

    logic                 tick_s;
    logic                 vote_evt_s;
    logic                 vote_s;
    logic                 start_edge_s;
    logic                 clear_div_s;
    logic [2:0]           state_nxt;
    logic [BIT_W-1:0]     bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 ferr_nxt;
    logic                 perr_nxt;
    logic                 done_nxt;

    assign tick_s       = (div_cnt_r == DIV_MAX);
    assign vote_evt_s   = tick_s && (samp_cnt_r == S_HI) && (state_r != ST_IDLE);
    assign vote_s       = majority3(v_lo_r, v_mid_r, rx_sync_r);
    assign start_edge_s = rx_prev_r && !rx_sync_r;

    // Two-flop synchroniser for rx plus a delayed copy for edge detection.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Sample-tick divider and sample counter, re-phased on every start edge.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= '0;
        end else if (clear_div_s) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= '0;
        end else if (tick_s) begin
            div_cnt_r  <= '0;
            samp_cnt_r <= (samp_cnt_r == SAMP_MAX) ? '0 : samp_cnt_r + SAMP_ONE;
        end else begin
            div_cnt_r  <= div_cnt_r + DIV_ONE;
        end
    end

    // Capture the first two centre samples; the third is rx_sync_r at vote time.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            v_lo_r  <= 1'b1;
            v_mid_r <= 1'b1;
        end else begin
            if (tick_s && (samp_cnt_r == S_LO)) begin
                v_lo_r <= rx_sync_r;
            end
            if (tick_s && (samp_cnt_r == S_MID)) begin
                v_mid_r <= rx_sync_r;
            end
        end
    end

    // Frame FSM next-state: all decisions happen on the per-bit vote event.
    always_comb begin
        state_nxt   = state_r;
        bit_cnt_nxt = bit_cnt_r;
        shift_nxt   = shift_r;
        ferr_nxt    = ferr_r;
        perr_nxt    = perr_r;
        done_nxt    = 1'b0;
        clear_div_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_nxt   = ST_START;
                    clear_div_s = 1'b1;
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                    ferr_nxt    = 1'b0;
                    perr_nxt    = 1'b0;
                end else begin
                    state_nxt   = ST_IDLE;
                end
            end
            ST_START: begin
                if (vote_evt_s) begin
                    // A high vote means the edge was a glitch: drop silently.
                    state_nxt = vote_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (vote_evt_s) begin
                    shift_nxt = {vote_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == BITS_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (vote_evt_s) begin
                    perr_nxt  = parity_mismatch(shift_r, vote_s);
                    state_nxt = ST_STOP;
                end else begin
                    state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (vote_evt_s) begin
                    ferr_nxt = ferr_r | ~vote_s;
                    // Finish at the last stop vote so a start edge in the
                    // second half of the stop bit is still caught.
                    if (bit_cnt_r == STOP_LAST) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_IDLE;
                        done_nxt    = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + BIT_ONE;
                    end
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    // Frame FSM state registers.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            ferr_r    <= 1'b0;
            perr_r    <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            shift_r   <= shift_nxt;
            ferr_r    <= ferr_nxt;
            perr_r    <= perr_nxt;
            done_r    <= done_nxt;
            busy_r    <= (state_nxt != ST_IDLE);
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            data_r       <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else if (done_r) begin
            if (valid_r && !ready) begin
                // Held word not yet taken: drop the new one.
                overrun_r <= 1'b1;
            end else begin
                data_r       <= shift_r;
                frame_err_r  <= ferr_r;
                parity_err_r <= perr_r;
                valid_r      <= 1'b1;
                overrun_r    <= 1'b0;
            end
        end else begin
            overrun_r <= 1'b0;
            if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Three instances cover the
//   configurations of interest: A = 8N1 defaults, B = 8 bits even parity,
//   C = 9 bits odd parity two stop bits. One serial driver feeds whichever
//   instance is selected; the others see an idle line.
// ----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int BIT_CLKS = 112;   // DIV=7 clocks per tick, 16 ticks per bit

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_c_pulse = 1'b0;
    logic       rst_c;
    logic       rx_line = 1'b1;
    int         sel = 0;
    logic       rx_a, rx_b, rx_c;
    logic       ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
    logic [7:0] data_a, data_b;
    logic [8:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       perr_a, perr_b, perr_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic       busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_a = 0, acc_b = 0, acc_c = 0;
    int vcyc_a = 0, ovcyc_a = 0;
    logic [8:0] last_a = '0, last_b = '0, last_c = '0;
    logic       lf_a = 1'b0, lf_b = 1'b0, lf_c = 1'b0;
    logic       lp_a = 1'b0, lp_b = 1'b0, lp_c = 1'b0;
    int waited = 0;

    assign rx_a  = (sel == 0) ? rx_line : 1'b1;
    assign rx_b  = (sel == 1) ? rx_line : 1'b1;
    assign rx_c  = (sel == 2) ? rx_line : 1'b1;
    assign rst_c = rst | rst_c_pulse;

    always #5 clk = ~clk;

    uart_rx_param dut_a (
        .clk_100M(clk), .rst(rst), .rx(rx_a), .data(data_a), .valid(valid_a),
        .ready(ready_a), .frame_err(ferr_a), .parity_err(perr_a),
        .overrun(ovr_a), .busy(busy_a)
    );

    uart_rx_param #(.PARITY(2)) dut_b (
        .clk_100M(clk), .rst(rst), .rx(rx_b), .data(data_b), .valid(valid_b),
        .ready(ready_b), .frame_err(ferr_b), .parity_err(perr_b),
        .overrun(ovr_b), .busy(busy_b)
    );

    uart_rx_param #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clk_100M(clk), .rst(rst_c), .rx(rx_c), .data(data_c), .valid(valid_c),
        .ready(ready_c), .frame_err(ferr_c), .parity_err(perr_c),
        .overrun(ovr_c), .busy(busy_c)
    );

    // Record every accepted word and count valid/overrun cycles, mid-cycle.
    always @(negedge clk) begin
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            acc_a <= acc_a + 1; last_a <= {1'b0, data_a}; lf_a <= ferr_a; lp_a <= perr_a;
        end
        if (valid_b === 1'b1 && ready_b === 1'b1) begin
            acc_b <= acc_b + 1; last_b <= {1'b0, data_b}; lf_b <= ferr_b; lp_b <= perr_b;
        end
        if (valid_c === 1'b1 && ready_c === 1'b1) begin
            acc_c <= acc_c + 1; last_c <= data_c; lf_c <= ferr_c; lp_c <= perr_c;
        end
        if (valid_a === 1'b1) vcyc_a <= vcyc_a + 1;
        if (ovr_a === 1'b1) ovcyc_a <= ovcyc_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit period; optional one-tick inverted glitch around the bit centre.
    task automatic drive_bit(input logic b, input bit glitch);
        rx_line = b;
        if (glitch) begin
            wait_clks(53);
            rx_line = ~b;
            wait_clks(7);
            rx_line = b;
            wait_clks(52);
        end else begin
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [8:0] word, input int nbits, input bit has_par,
                              input logic par_bit, input int nstop, input logic stop_val,
                              input int glitch_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(word[i], glitch_bit == i);
        if (has_par) drive_bit(par_bit, 1'b0);
        drive_bit(stop_val, 1'b0);
        for (int i = 1; i < nstop; i++) drive_bit(1'b1, 1'b0);
        rx_line = 1'b1;
    endtask

    initial begin
        // Reset values
        wait_clks(5);
        check("rst_data",  {24'd0, data_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_ferr",  {31'd0, ferr_a}, 32'd0);
        check("rst_perr",  {31'd0, perr_a}, 32'd0);
        check("rst_ovr",   {31'd0, ovr_a}, 32'd0);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        wait_clks(20);
        check("idle_busy", {31'd0, busy_a}, 32'd0);

        // 1: 0xA5 with a one-tick glitch in bit 0
        sel = 0; ready_a = 1'b1;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 0);
        wait_clks(20);
        check("t1_count", acc_a, 32'd1);
        check("t1_vcyc",  vcyc_a, 32'd1);
        check("t1_data",  {23'd0, last_a}, 32'h0A5);
        check("t1_ferr",  {31'd0, lf_a}, 32'd0);
        check("t1_perr",  {31'd0, lp_a}, 32'd0);

        // 2: even parity, correct then wrong parity bit
        sel = 1; ready_b = 1'b1;
        send_frame(9'h03C, 8, 1'b1, 1'b0, 1, 1'b1, -1);
        wait_clks(20);
        check("t2a_count", acc_b, 32'd1);
        check("t2a_data",  {23'd0, last_b}, 32'h03C);
        check("t2a_perr",  {31'd0, lp_b}, 32'd0);
        send_frame(9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, -1);
        wait_clks(20);
        check("t2b_count", acc_b, 32'd2);
        check("t2b_data",  {23'd0, last_b}, 32'h03C);
        check("t2b_perr",  {31'd0, lp_b}, 32'd1);
        check("t2b_ferr",  {31'd0, lf_b}, 32'd0);

        // 3: stop bit forced low, then a clean word
        sel = 0;
        send_frame(9'h081, 8, 1'b0, 1'b0, 1, 1'b0, -1);
        wait_clks(BIT_CLKS);
        check("t3a_count", acc_a, 32'd2);
        check("t3a_data",  {23'd0, last_a}, 32'h081);
        check("t3a_ferr",  {31'd0, lf_a}, 32'd1);
        send_frame(9'h012, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        wait_clks(20);
        check("t3b_count", acc_a, 32'd3);
        check("t3b_data",  {23'd0, last_a}, 32'h012);
        check("t3b_ferr",  {31'd0, lf_a}, 32'd0);

        // 4: false start, low for 3 sample ticks
        rx_line = 1'b0;
        wait_clks(10);
        check("t4_busy_high", {31'd0, busy_a}, 32'd1);
        wait_clks(11);
        rx_line = 1'b1;
        waited = 0;
        while (busy_a !== 1'b0 && waited < BIT_CLKS) begin
            wait_clks(1);
            waited++;
        end
        check("t4_busy_clear", {31'd0, busy_a}, 32'd0);
        wait_clks(BIT_CLKS);
        check("t4_count", acc_a, 32'd3);
        check("t4_valid", {31'd0, valid_a}, 32'd0);
        check("t4_ovr",   ovcyc_a, 32'd0);

        // 5: overrun with ready low, back-to-back frames
        ready_a = 1'b0;
        send_frame(9'h0AA, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        send_frame(9'h0BB, 8, 1'b0, 1'b0, 1, 1'b1, -1);
        wait_clks(20);
        check("t5_valid", {31'd0, valid_a}, 32'd1);
        check("t5_data",  {24'd0, data_a}, 32'h0AA);
        check("t5_ovr_cycles", ovcyc_a, 32'd1);
        ready_a = 1'b1;
        @(negedge clk);
        check("t5_valid_at_accept", {31'd0, valid_a}, 32'd1);
        @(posedge clk); #1;
        check("t5_valid_fall", {31'd0, valid_a}, 32'd0);
        wait_clks(2 * BIT_CLKS);
        check("t5_count", acc_a, 32'd4);
        check("t5_last",  {23'd0, last_a}, 32'h0AA);
        check("t5_no_bb", {31'd0, valid_a}, 32'd0);

        // 6: 9O2, reset during data bit 4, then 0x1F3
        sel = 2; ready_c = 1'b1;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx_line = 1'b1;
        wait_clks(50);
        check("t6_busy_before", {31'd0, busy_c}, 32'd1);
        rst_c_pulse = 1'b1;
        wait_clks(3);
        check("t6_busy_rst", {31'd0, busy_c}, 32'd0);
        rst_c_pulse = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("t6_abort_count", acc_c, 32'd0);
        check("t6_abort_valid", {31'd0, valid_c}, 32'd0);
        send_frame(9'h1F3, 9, 1'b1, 1'b0, 2, 1'b1, -1);
        wait_clks(20);
        check("t6_count", acc_c, 32'd1);
        check("t6_data",  {23'd0, last_c}, 32'h1F3);
        check("t6_ferr",  {31'd0, lf_c}, 32'd0);
        check("t6_perr",  {31'd0, lp_c}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 byte receiver. It supports configurable data width, parity mode and stop-bit count, 16x oversampling with 3-sample majority vote, and false-start rejection. Each received word is presented through a valid/ready holding register with per-word frame/parity error flags and an overrun pulse. It sits between the board RX pin and command/stream parsers in the clk_100M domain.

Parameters:
CLK_FREQ, 100_000_000, input clock frequency in Hz
BAUD_RATE, 921600, line baud rate
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, sample ticks per bit, even, at least 8

Ports:
clk_100M  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx  in  1  serial line, idle high, asynchronous to clk_100M
data  out  DATA_BITS  received word, LSB first on the line
valid  out  1  data and flags hold a word
ready  in  1  consumer accepts the word on a cycle where valid && ready
frame_err  out  1  word had a 0 sampled in a stop bit; qualified by valid
parity_err  out  1  parity mismatch; qualified by valid; always 0 when PARITY=0
overrun  out  1  one-cycle pulse: a completed word was dropped
busy  out  1  receiver FSM is not in IDLE

Behaviour:
- Reset values: data=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, FSM=IDLE, rx synchroniser flops=1.
- rx passes through a 2-flop synchroniser. All logic uses the synchronised value rx_s.
- Tick divider: DIV = (CLK_FREQ*10/(BAUD_RATE*OVERSAMPLE)+5)/10, i.e. rounded. With defaults DIV=7.
  - The divider emits a 1-cycle tick every DIV clocks.
  - The divider and the sample counter (0..OVERSAMPLE-1) are cleared on the start edge, so bit phase is aligned to the start edge.
- Bit value per bit period: majority of rx_s at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. It is evaluated at count OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s falling edge (previous 1, current 0) goes to START.
  - START: if the vote is 1, this is a false start: return to IDLE with no flags and no output. If the vote is 0, go to DATA.
  - DATA: shift votes in LSB first. After DATA_BITS bits, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: parity_err_int = (XOR of data bits XOR parity vote) != (PARITY==1 ? 1 : 0). Then go to STOP.
  - STOP: for each of the STOP_BITS bits, a 0 vote sets frame_err_int. At the vote of the last stop bit, complete the word and go directly to IDLE. There is no wait for the end of the bit, so a start edge in the second half of the stop bit is accepted.
- Completion: the word is written to the output register on the clock after the last stop vote. valid, frame_err and parity_err update on that same edge.
- Break condition (all data bits 0 and stop bit 0) is delivered as a normal word with frame_err=1.
- Handshake:
  - valid stays high, and data/flags stay stable, until a cycle with valid && ready. valid falls on the next edge.
  - Completion on a cycle with valid && !ready: the new word is discarded, the held word is unchanged, and overrun pulses for one cycle.
  - Completion on a cycle with valid && ready: the new word is loaded, valid stays 1, and no overrun occurs.
- No receive state persists across frames except the output register.
- rst mid-frame: all state returns to reset values immediately. A partial frame is never delivered.

Test Plan:
1. Defaults (8N1, DIV=7), send 0xA5 with a 1-sample-tick low glitch at the centre of bit 0, ready=1 -> one valid pulse, data=0xA5, frame_err=0, parity_err=0.
2. PARITY=2, send 0x3C with correct parity bit 0, then 0x3C with parity bit 1 -> data=0x3C both times; parity_err=0 then 1.
3. Send 0x81 with stop bit forced to 0, then 0x12 normally -> first word 0x81 with frame_err=1; second word 0x12 with frame_err=0.
4. Drive rx low for 3 sample ticks, then high (false start) -> no valid, busy returns to 0 within 1 bit time, no flags.
5. ready=0, send 0xAA then 0xBB back-to-back -> data=0xAA held, overrun high exactly 1 cycle at the second completion. Then assert ready -> valid falls next edge; 0xBB is never presented.
6. DATA_BITS=9, STOP_BITS=2, PARITY=1, assert rst at data bit 4 and release, then send 0x1F3 -> no output for the aborted frame; data=0x1F3, both error flags 0.
